// File: rtl/dmem_responder_if.sv
// -----------------------------------------------------------------------------
// dmem_responder_if
//   Bus between the MEM stage (master) and the data-memory responder (slave).
//
//   req    master->slave  request valid, held until ready is seen
//   we     master->slave  1 = store, 0 = load
//   addr   master->slave  byte address
//   wdata  master->slave  store data
//   be     master->slave  byte enables, be[0] selects wdata[7:0]
//   rdata  slave->master  load data, valid while ready=1
//   ready  slave->master  one-cycle response pulse
//   err    slave->master  error response, valid while ready=1
//   stall  slave->master  pipeline stall = req & ~ready
// -----------------------------------------------------------------------------
interface dmem_responder_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
    logic        ready;
    logic        err;
    logic        stall;

    modport master (
        output req, we, addr, wdata, be,
        input  rdata, ready, err, stall
    );

    modport slave (
        input  req, we, addr, wdata, be,
        output rdata, ready, err, stall
    );
endinterface

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//   Data-memory responder for the pipelined MIPS core. Accepts one load/store
//   from the MEM stage, waits LATENCY states, then answers with a one-cycle
//   ready pulse. Word-organised RAM with byte-enable writes; stall is raised
//   toward the pipeline while a request is outstanding.
//
//   Parameters
//     DEPTH    number of 32-bit words (word index = addr[31:2])
//     LATENCY  wait states between accept and response, 0..15
//
//   Ports
//     clk    rising-edge clock
//     reset  synchronous active-low reset (0 = reset)
//     bus    slave side of dmem_responder_if
// -----------------------------------------------------------------------------
module dmem_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic             clk,
    input  logic             reset,
    dmem_responder_if.slave  bus
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [29:0] DEPTH_W = 30'(DEPTH);
    localparam logic [3:0]  LAT_M1  = 4'((LATENCY > 0) ? LATENCY - 1 : 0);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state, state_next;
    logic [3:0]  counter, counter_next;

    // Request captured at the accept edge.
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;

    // Operation actually performed at RESP entry. With LATENCY=0 the entry
    // edge is the accept edge itself, so the live bus values are used then.
    logic        op_we;
    logic [31:0] op_addr;
    logic [31:0] op_wdata;
    logic [3:0]  op_be;
    logic [AW-1:0] op_idx;
    logic        op_err;
    logic        enter_resp;

    logic [31:0] rdata_q;
    logic        err_q;
    logic        ready;

    logic [31:0] mem [DEPTH];

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        op_we    = we_q;
        op_addr  = addr_q;
        op_wdata = wdata_q;
        op_be    = be_q;
        if (state == IDLE) begin
            op_we    = bus.we;
            op_addr  = bus.addr;
            op_wdata = bus.wdata;
            op_be    = bus.be;
        end
    end

    assign op_idx = op_addr[AW+1:2];

    // Misaligned full-word store, misaligned load, or word index past the RAM.
    assign op_err = ((op_addr[1:0] != 2'b00) && (!op_we || op_be == 4'hF))
                  || (op_addr[31:2] >= DEPTH_W);

    always_comb begin
        state_next   = state;
        counter_next = counter;
        enter_resp   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req) begin
                    if (LATENCY == 0) begin
                        state_next = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_next   = WAIT;
                        counter_next = LAT_M1;
                    end
                end
            end
            WAIT: begin
                if (counter == 4'd0) begin
                    state_next = RESP;
                    enter_resp = 1'b1;
                end else begin
                    counter_next = counter - 4'd1;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!reset) begin
            state   <= IDLE;
            counter <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_next;
            counter <= counter_next;
            if (state == IDLE && bus.req) begin
                we_q    <= bus.we;
                addr_q  <= bus.addr;
                wdata_q <= bus.wdata;
                be_q    <= bus.be;
            end
            // Response data exists only during the RESP cycle.
            rdata_q <= '0;
            err_q   <= 1'b0;
            if (enter_resp) begin
                err_q <= op_err;
                if (!op_we && !op_err) begin
                    rdata_q <= mem[op_idx];
                end
            end
        end
    end

    // NOTE: the RAM array has no reset; reset only blocks a write landing on the same edge.
    always_ff @(posedge clk) begin
        if (reset && enter_resp && op_we && !op_err) begin
            for (int b = 0; b < 4; b++) begin
                if (op_be[b]) begin
                    mem[op_idx][8*b +: 8] <= op_wdata[8*b +: 8];
                end
            end
        end
    end

    assign ready     = (state == RESP);
    assign bus.ready = ready;
    assign bus.rdata = rdata_q;
    assign bus.err   = err_q;
    assign bus.stall = bus.req & ~ready;

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//   Two responders: dut_a with LATENCY=2 and dut_b with LATENCY=0, both
//   DEPTH=1024. A table of directed transactions runs first, followed by
//   hand-written back-to-back, reset-abort and LATENCY=0 timing sequences.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic        req_a = 1'b0;
    logic        req_b = 1'b0;
    logic        t_we = 1'b0;
    logic [31:0] t_addr = '0;
    logic [31:0] t_wdata = '0;
    logic [3:0]  t_be = '0;
    logic        sel_r = 1'b0;

    dmem_responder_if if_a ();
    dmem_responder_if if_b ();

    assign if_a.req   = req_a;
    assign if_a.we    = t_we;
    assign if_a.addr  = t_addr;
    assign if_a.wdata = t_wdata;
    assign if_a.be    = t_be;
    assign if_b.req   = req_b;
    assign if_b.we    = t_we;
    assign if_b.addr  = t_addr;
    assign if_b.wdata = t_wdata;
    assign if_b.be    = t_be;

    dmem_responder #(.DEPTH(1024), .LATENCY(2)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (if_a)
    );

    dmem_responder #(.DEPTH(1024), .LATENCY(0)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (if_b)
    );

    wire        rdy = sel_r ? if_b.ready : if_a.ready;
    wire        stl = sel_r ? if_b.stall : if_a.stall;
    wire        erv = sel_r ? if_b.err   : if_a.err;
    wire [31:0] rdt = sel_r ? if_b.rdata : if_a.rdata;

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    typedef struct {
        bit          sel;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    localparam int NV = 24;
    vec_t vecs [NV];

    // One transaction: drive in an IDLE cycle, wait (bounded) for ready.
    task automatic txn(input bit sel, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be,
                       output logic [31:0] rd, output logic er, output int lat,
                       output int stalls, output logic stall_rdy);
        @(negedge clk);
        sel_r   = sel;
        t_we    = we;
        t_addr  = addr;
        t_wdata = wdata;
        t_be    = be;
        if (sel) req_b = 1'b1; else req_a = 1'b1;
        #1;
        stalls = stl ? 1 : 0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (!rdy && stl) stalls++;
        end while (!rdy && lat < 20);
        rd        = rdt;
        er        = erv;
        stall_rdy = stl;
        req_a = 1'b0;
        req_b = 1'b0;
    endtask

    task automatic count_ready_a(input int cycles, output int cnt);
        cnt = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (if_a.ready) cnt++;
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        logic        sr;
        int          lat;
        int          stalls;
        int          cnt;
        int          exp_lat;
        int          last;
        int          k;
        logic [31:0] b2b_addr [3];
        logic [31:0] b2b_data [3];

        vecs[0]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'b1111, 32'h0,          1'b0};
        vecs[1]  = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,         4'b1111, 32'hDEAD_BEEF, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 32'h0000_0020, 32'h1122_3344, 4'b1111, 32'h0,          1'b0};
        vecs[3]  = '{1'b0, 1'b1, 32'h0000_0020, 32'hAABB_CCDD, 4'b0101, 32'h0,          1'b0};
        vecs[4]  = '{1'b0, 1'b0, 32'h0000_0020, 32'h0,         4'b1111, 32'h11BB_33DD, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 32'h0000_0013, 32'h0,         4'b1111, 32'h0,          1'b1};
        vecs[6]  = '{1'b0, 1'b1, 32'h0000_0000, 32'hCAFE_F00D, 4'b1111, 32'h0,          1'b0};
        vecs[7]  = '{1'b0, 1'b1, 32'h0000_1000, 32'h1234_5678, 4'b1111, 32'h0,          1'b1};
        vecs[8]  = '{1'b0, 1'b0, 32'h0000_0000, 32'h0,         4'b1111, 32'hCAFE_F00D, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 32'h0000_0022, 32'hFFFF_FFFF, 4'b1111, 32'h0,          1'b1};
        vecs[10] = '{1'b0, 1'b0, 32'h0000_0020, 32'h0,         4'b1111, 32'h11BB_33DD, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 32'h0000_0021, 32'h0000_BEEF, 4'b0011, 32'h0,          1'b0};
        vecs[12] = '{1'b0, 1'b0, 32'h0000_0020, 32'h0,         4'b1111, 32'h11BB_BEEF, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 32'h0000_0020, 32'hFFFF_FFFF, 4'b0000, 32'h0,          1'b0};
        vecs[14] = '{1'b0, 1'b0, 32'h0000_0020, 32'h0,         4'b1111, 32'h11BB_BEEF, 1'b0};
        vecs[15] = '{1'b0, 1'b1, 32'h0000_0FFC, 32'h0F0F_0F0F, 4'b1111, 32'h0,          1'b0};
        vecs[16] = '{1'b0, 1'b0, 32'h0000_0FFC, 32'h0,         4'b1111, 32'h0F0F_0F0F, 1'b0};
        vecs[17] = '{1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0,         4'b1111, 32'h0,          1'b1};
        vecs[18] = '{1'b0, 1'b1, 32'h0000_0040, 32'h0000_0000, 4'b1111, 32'h0,          1'b0};
        vecs[19] = '{1'b0, 1'b0, 32'h0000_0040, 32'h0,         4'b1111, 32'h0,          1'b0};
        vecs[20] = '{1'b1, 1'b1, 32'h0000_0008, 32'h1357_2468, 4'b1111, 32'h0,          1'b0};
        vecs[21] = '{1'b1, 1'b0, 32'h0000_0008, 32'h0,         4'b1111, 32'h1357_2468, 1'b0};
        vecs[22] = '{1'b1, 1'b0, 32'h0000_0009, 32'h0,         4'b1111, 32'h0,          1'b1};
        vecs[23] = '{1'b1, 1'b1, 32'h0000_1000, 32'h5555_AAAA, 4'b1111, 32'h0,          1'b1};

        // Reset state; stall follows req even while in reset.
        repeat (2) @(negedge clk);
        check("reset ready", 32'(if_a.ready), 32'h0);
        check("reset err",   32'(if_a.err),   32'h0);
        check("reset rdata", if_a.rdata,      32'h0);
        check("reset stall req0", 32'(if_a.stall), 32'h0);
        req_a = 1'b1;
        #1;
        check("reset stall req1", 32'(if_a.stall), 32'h1);
        req_a = 1'b0;
        reset = 1'b1;

        for (int i = 0; i < NV; i++) begin
            txn(vecs[i].sel, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be,
                rd, er, lat, stalls, sr);
            exp_lat = vecs[i].sel ? 1 : 3;
            check($sformatf("v%0d latency", i), 32'(lat), 32'(exp_lat));
            check($sformatf("v%0d stall cycles", i), 32'(stalls), 32'(exp_lat));
            check($sformatf("v%0d stall at ready", i), 32'(sr), 32'h0);
            check($sformatf("v%0d rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("v%0d err", i), 32'(er), 32'(vecs[i].exp_err));
        end

        // Back-to-back: req held high across three loads.
        b2b_addr[0] = 32'h10; b2b_data[0] = 32'hDEAD_BEEF;
        b2b_addr[1] = 32'h20; b2b_data[1] = 32'h11BB_BEEF;
        b2b_addr[2] = 32'h00; b2b_data[2] = 32'hCAFE_F00D;
        @(negedge clk);
        sel_r  = 1'b0;
        t_we   = 1'b0;
        t_addr = b2b_addr[0];
        req_a  = 1'b1;
        k = 0;
        last = -1;
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            if (if_a.ready) begin
                if (k < 3) check($sformatf("b2b rdata %0d", k), if_a.rdata, b2b_data[k]);
                if (last >= 0) check($sformatf("b2b spacing %0d", k), 32'(c - last), 32'd4);
                last = c;
                k++;
                if (k < 3) t_addr = b2b_addr[k];
                else req_a = 1'b0;
            end
        end
        check("b2b ready count", 32'(k), 32'd3);

        // Reset during WAIT: store must be dropped.
        @(negedge clk);
        t_we = 1'b1; t_addr = 32'h40; t_wdata = 32'h5555_5555; t_be = 4'hF;
        req_a = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        req_a = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("wait abort ready", 32'(if_a.ready), 32'h0);
        check("wait abort err",   32'(if_a.err),   32'h0);
        check("wait abort rdata", if_a.rdata,      32'h0);
        count_ready_a(6, cnt);
        check("wait abort no ready", 32'(cnt), 32'h0);
        txn(1'b0, 1'b0, 32'h40, 32'h0, 4'hF, rd, er, lat, stalls, sr);
        check("wait abort load", rd, 32'h0);

        // Reset on the RESP-entry edge: reset wins, no write.
        @(negedge clk);
        t_we = 1'b1; t_addr = 32'h40; t_wdata = 32'h7777_7777; t_be = 4'hF;
        req_a = 1'b1;
        @(negedge clk);
        req_a = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("resp abort ready", 32'(if_a.ready), 32'h0);
        count_ready_a(6, cnt);
        check("resp abort no ready", 32'(cnt), 32'h0);
        txn(1'b0, 1'b0, 32'h40, 32'h0, 4'hF, rd, er, lat, stalls, sr);
        check("resp abort load", rd, 32'h0);

        // Reset and req together: the request is not accepted.
        @(negedge clk);
        reset = 1'b0;
        t_we = 1'b0; t_addr = 32'h10;
        req_a = 1'b1;
        #1;
        check("reset+req stall", 32'(if_a.stall), 32'h1);
        @(negedge clk);
        reset = 1'b1;
        req_a = 1'b0;
        count_ready_a(6, cnt);
        check("reset+req no ready", 32'(cnt), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the pipelined MIPS core: the MEM stage issues load/store requests, and this block answers them after a programmable number of wait states.
- Holds word-organised RAM with byte-enable writes. Drives a stall indication back to the pipeline while a request is outstanding.
- Sits between the MEM-stage register outputs and the MEM/WB register; replaces the zero-latency data memory for wait-state testing.

Parameters:
- DEPTH, 1024, number of 32-bit words; the word index is addr[31:2], width clog2(DEPTH).
- LATENCY, 2, wait states between accept and response (0..15); 0 means ready in the cycle after accept.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset), sampled on clk rising edge.
- req  input  1  request valid from MEM stage; held high until ready is seen.
- we  input  1  1 = store, 0 = load.
- addr  input  32  byte address.
- wdata  input  32  store data.
- be  input  4  byte enables; be[0] selects wdata[7:0].
- rdata  output  32  load data; valid only while ready=1.
- ready  output  1  one-cycle response pulse.
- err  output  1  response is an error; valid only while ready=1.
- stall  output  1  pipeline stall = req & ~ready (combinational).

Behaviour:
- Reset (reset=0 at edge): state=IDLE, counter=0, ready=0, err=0, rdata=0; stall follows req. RAM contents are not cleared.
- States: IDLE, WAIT, RESP.
- IDLE:
  - req=1 at an edge latches we/addr/wdata/be and accepts the request.
  - Next state is WAIT with counter=LATENCY-1, or RESP directly when LATENCY=0.
- WAIT: counter decrements each edge; at counter=0 the next edge enters RESP.
- Entry to RESP (the accept edge + LATENCY edges later):
  - Store: RAM word updated byte-wise per latched be; rdata=0.
  - Load: rdata = RAM word.
- RESP lasts one cycle with ready=1, then returns to IDLE unconditionally.
- Timing:
  - ready is high exactly LATENCY+1 cycles after the cycle in which req was accepted.
  - The minimum spacing between accepts is LATENCY+2 cycles; there is a one-cycle IDLE bubble after each response.
- Latched request: inputs changing during WAIT/RESP are ignored; only latched values are used.
- Error (evaluated on latched addr):
  - Conditions: addr[1:0]!=0 on a store with be=4'b1111, or addr[1:0]!=0 on any load, or word index >= DEPTH.
  - Result: no RAM write, rdata=0, err=1 during RESP; latency is unchanged.
- be=4'b0000 store: completes normally, RAM unchanged, err=0.
- Load of an address stored in the immediately preceding transaction returns the new data; there is no stale-read window.
- req=0 while in WAIT (protocol violation): the transaction still completes; ready still pulses.
- Reset mid-operation: an abort in WAIT leaves RAM unchanged. An abort at the RESP-entry edge loses to reset, so no write occurs. ready is 0 in the next cycle.
- Simultaneous reset=0 and req=1: reset wins; the request is not accepted.

Test Plan:
- LATENCY=2: store addr=0x10, wdata=0xDEADBEEF, be=1111, req held -> stall=1 for 3 cycles, ready=1 on the 4th, err=0. Then load 0x10 -> rdata=0xDEADBEEF with ready 3 cycles after accept.
- Byte enables: word 0x20=0x11223344, then store wdata=0xAABBCCDD with be=0101 -> load 0x20 returns 0x11BB33DD.
- Errors:
  - Load addr=0x13 -> ready on schedule, err=1, rdata=0.
  - Store to word index DEPTH (addr=0x1000 at DEPTH=1024) -> err=1, and a follow-up load of 0x0 is unchanged.
- Back-to-back: req held continuously for 3 loads -> ready pulses 4 cycles apart (LATENCY+2), exactly one per request, never two consecutive ready cycles.
- Reset mid-WAIT: start store 0x55555555 to 0x40 (old 0x0), drive reset=0 for one edge during WAIT -> ready never pulses for it, ready=0/err=0/rdata=0, and load 0x40 returns 0x0.
- LATENCY=0 build: load -> ready in the cycle immediately after accept, stall high for exactly 1 cycle.
